in_port_intr_ctrl: RTL and testbench
====================================

Name: in_port_intr_ctrl

Overview:
- Peripheral-side feeder for the processor core's input port and interrupt pin; sits directly upstream of the core top level.
- Accepts bytes from an external producer over a valid/ready handshake and buffers them in a small FIFO.
- Delivers one byte at a time: drives the byte on `in_port`, raises `intr` for a fixed pulse, then holds the byte stable for the core's ISR window before popping it.
- Output `in_port` connects to the core's `In_port`; output `intr` connects to the core's `int`.

Parameters:
- DEPTH, 4: FIFO entries; power of 2, minimum 2.
- INT_PULSE, 2: cycles `intr` stays high per byte; minimum 1.
- HOLD_CYCLES, 4: cycles `in_port` is held after the pulse, before the pop; minimum 1.
- GAP_CYCLES, 1: idle cycles after the pop, before the next delivery; 0 allowed.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  delivery enable; sampled only in IDLE.
- s_valid  in  1  producer has a byte.
- s_data  in  8  producer byte.
- s_ready  out  1  FIFO can accept.
- in_port  out  8  byte presented to the core.
- intr  out  1  interrupt request to the core.
- busy  out  1  delivery in progress (state != IDLE).
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- One clock `clk`. Reset `rst` is synchronous and active-high; it wins over every other input.
- Reset values:
  - s_ready=1, in_port=8'h00, intr=0, busy=0, level=0.
  - State=IDLE, FIFO pointers=0.
  - Any pending bytes are discarded.
  - Reset mid-delivery aborts at once; `intr` drops the next cycle.
- FIFO:
  - Push when s_valid&&s_ready.
  - s_ready = (level != DEPTH), combinational from level. When full, a same-cycle pop does not enable a push.
  - Pointers are $clog2(DEPTH)+1 bits, so they wrap naturally; the MSB distinguishes full from empty.
  - Push and pop in the same cycle leave level unchanged.
- FSM states: IDLE, ASSERT, HOLD, GAP. One down-counter is shared, sized for max(INT_PULSE, HOLD_CYCLES, GAP_CYCLES).
- IDLE:
  - If en && level!=0: register in_port<=FIFO head, intr<=1, cnt<=INT_PULSE-1, go to ASSERT.
  - Otherwise stay in IDLE. in_port keeps the last delivered byte.
- ASSERT:
  - intr=1. When cnt==0: intr<=0, cnt<=HOLD_CYCLES-1, go to HOLD. Otherwise cnt--.
- HOLD:
  - intr=0, in_port stable. When cnt==0: pop the FIFO. Then go to GAP with cnt<=GAP_CYCLES-1, or to IDLE if GAP_CYCLES==0. Otherwise cnt--.
- GAP:
  - When cnt==0 go to IDLE, otherwise cnt--.
- Latency:
  - A byte pushed into an empty, idle FIFO at edge N gives level=1 after N.
  - IDLE then loads at edge N+1, so in_port and intr are valid after N+1.
- Throughput: with a non-empty FIFO, one byte every 1+INT_PULSE+HOLD_CYCLES+GAP_CYCLES cycles (8 at defaults).
- `en` deasserted mid-delivery: the current byte completes fully (pulse, hold, pop). No new delivery starts until `en` is high in IDLE.
- The core's HLT is not an input. `intr` is the core's wake source, so deliveries continue regardless of halt.
- `in_port` changes only on the IDLE→ASSERT transition or on reset. It never changes during ASSERT, HOLD or GAP.
- `level` is the registered occupancy. `busy` is combinational from the state register.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=2'd0, ASSERT=2'd1, HOLD=2'd2, GAP=2'd3).
  - Port width constant (8).
- One sub-module: `sync_fifo` (parameters WIDTH, DEPTH).
  - Push and pop, full/empty, level.
  - Head data read combinationally.
- Top block holds the FSM, the counter and the output registers.

Test Plan:
- Reset then idle, en=1, no push → s_ready=1, intr=0, in_port=0x00, level=0, busy=0 for 20 cycles.
- Single push 0xA5 at edge N (defaults) → in_port=0xA5 and intr=1 during cycles N+2..N+3. intr=0 from N+4. level goes 1→0 at the last HOLD edge (edge N+7). in_port still 0xA5 afterwards.
- Push 0x11, 0x22, 0x33, 0x44, 0x55 back-to-back → s_ready drops after the 4th push (level=4) and 0x55 stalls until the first pop. Bytes delivered in order. Successive intr rising edges are exactly 8 cycles apart.
- en=0 with 2 bytes queued → no intr, level=2. Raise en → delivery starts the next cycle. Drop en during ASSERT → that byte completes, the next does not start.
- Assert rst during HOLD with level=3 → the next cycle shows intr=0, in_port=0x00, level=0, busy=0, s_ready=1. No delivery follows.
- GAP_CYCLES=0, INT_PULSE=1, HOLD_CYCLES=1 instance with 3 bytes queued → intr pulses 1 cycle wide, every 3 cycles.

Source files
------------

// File: rtl/in_port_intr_ctrl_pkg.sv
// Shared types and constants for the input-port / interrupt feeder.
package in_port_intr_ctrl_pkg;

  localparam int unsigned PORT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_HOLD   = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/in_port_intr_ctrl_if.sv
// Producer-side valid/ready byte stream into the feeder.
interface in_port_intr_ctrl_if;
  import in_port_intr_ctrl_pkg::*;

  logic              s_valid;
  logic [PORT_W-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/in_port_intr_ctrl_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers, registered level and combinational head.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rptr_q[AW-1:0]];
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + PTR_ONE;
        2'b01:   level_q <= level_q - PTR_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/in_port_intr_ctrl.sv
// Feeds buffered bytes to the core's input port, one interrupt pulse per byte,
// holding each byte stable through the ISR window before popping it.
module in_port_intr_ctrl
  import in_port_intr_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned INT_PULSE   = 2,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  in_port_intr_ctrl_if.slave     s,
  output logic [PORT_W-1:0]      in_port,
  output logic                   intr,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned CNT_MAX = max3(INT_PULSE, HOLD_CYCLES, GAP_CYCLES);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] INT_LD  = CNT_W'(INT_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  // Guarded so a zero gap never evaluates a negative reload value.
  localparam logic [CNT_W-1:0] GAP_LD  = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              intr_q;
  logic [PORT_W-1:0] in_port_q;

  logic [PORT_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;

  assign s.s_ready = !fifo_full;
  assign fifo_push = s.s_valid && !fifo_full;
  assign fifo_pop  = (state_q == ST_HOLD) && (cnt_q == '0);

  sync_fifo #(
    .WIDTH (PORT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (s.s_data),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      intr_q    <= 1'b0;
      in_port_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en && !fifo_empty) begin
            in_port_q <= fifo_head;
            intr_q    <= 1'b1;
            cnt_q     <= INT_LD;
            state_q   <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          if (cnt_q == '0) begin
            intr_q  <= 1'b0;
            cnt_q   <= HOLD_LD;
            state_q <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            if (GAP_CYCLES == 0) begin
              state_q <= ST_IDLE;
            end else begin
              cnt_q   <= GAP_LD;
              state_q <= ST_GAP;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) state_q <= ST_IDLE;
          else             cnt_q   <= cnt_q - CNT_ONE;
        end
      endcase
    end
  end

  assign in_port = in_port_q;
  assign intr    = intr_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_in_port_intr_ctrl.sv
// Directed bench for in_port_intr_ctrl: default instance plus a minimal-timing instance.
module tb_in_port_intr_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, en_f;
  logic [7:0] in_port, in_port_f;
  logic       intr, intr_f, busy, busy_f;
  logic [2:0] level, level_f;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  in_port_intr_ctrl_if bus ();
  in_port_intr_ctrl_if bus_f ();

  in_port_intr_ctrl #(.DEPTH(4), .INT_PULSE(2), .HOLD_CYCLES(4), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .en(en), .s(bus),
    .in_port(in_port), .intr(intr), .busy(busy), .level(level));

  in_port_intr_ctrl #(.DEPTH(4), .INT_PULSE(1), .HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_f (
    .clk(clk), .rst(rst), .en(en_f), .s(bus_f),
    .in_port(in_port_f), .intr(intr_f), .busy(busy_f), .level(level_f));

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      total++;
      if ({bus.s_ready, intr, in_port, level, busy} !== {1'b1, 1'b0, 8'h00, 3'd0, 1'b0}) begin
        bad++;
        $display("FAIL reset_idle cyc%0d: got rdy=%b intr=%b port=%h lvl=%0d busy=%b want 1 0 00 0 0",
                 i, bus.s_ready, intr, in_port, level, busy);
      end
    end
  endtask

  task automatic test_single();
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hA5;
    step(1);
    bus.s_valid = 1'b0;
    total++;
    if ({level, intr, busy} !== {3'd1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL single_N: got lvl=%0d intr=%b busy=%b want 1 0 0", level, intr, busy);
    end
    step(1);
    total++;
    if ({intr, in_port, busy} !== {1'b1, 8'hA5, 1'b1}) begin
      bad++; $display("FAIL single_N1: got intr=%b port=%h busy=%b want 1 a5 1", intr, in_port, busy);
    end
    step(1);
    total++;
    if (intr !== 1'b1) begin bad++; $display("FAIL single_N2_intr: got %b want 1", intr); end
    step(1);
    total++;
    if ({intr, in_port} !== {1'b0, 8'hA5}) begin
      bad++; $display("FAIL single_N3: got intr=%b port=%h want 0 a5", intr, in_port);
    end
    step(3);
    total++;
    if (level !== 3'd1) begin bad++; $display("FAIL single_N6_level: got %0d want 1", level); end
    step(1);
    total++;
    if ({level, in_port, busy} !== {3'd0, 8'hA5, 1'b1}) begin
      bad++; $display("FAIL single_N7: got lvl=%0d port=%h busy=%b want 0 a5 1", level, in_port, busy);
    end
    step(1);
    total++;
    if ({busy, in_port} !== {1'b0, 8'hA5}) begin
      bad++; $display("FAIL single_N8: got busy=%b port=%h want 0 a5", busy, in_port);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q [5];
    int   np = 0;
    int   nd = 0;
    int   last_rise = -1;
    logic prev_intr;
    logic accepted;
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    prev_intr = intr;
    for (int e = 0; e < 46; e++) begin
      bus.s_valid = (np < 5);
      if (np < 5) bus.s_data = q[np];
      accepted = bus.s_valid && bus.s_ready;
      step(1);
      if (accepted) begin
        np++;
        if (np == 4) begin
          total++;
          if ({bus.s_ready, level} !== {1'b0, 3'd4}) begin
            bad++; $display("FAIL b2b_full: got rdy=%b lvl=%0d want 0 4", bus.s_ready, level);
          end
        end
        if (np == 5) begin
          total++;
          if (e !== 8) begin bad++; $display("FAIL b2b_stall_edge: got %0d want 8", e); end
        end
      end
      if (intr && !prev_intr) begin
        total++;
        if (nd < 5 && in_port !== q[nd]) begin
          bad++; $display("FAIL b2b_order%0d: got %h want %h", nd, in_port, q[nd]);
        end
        if (nd > 0) begin
          total++;
          if (e - last_rise !== 8) begin
            bad++; $display("FAIL b2b_spacing%0d: got %0d want 8", nd, e - last_rise);
          end
        end
        last_rise = e;
        nd++;
      end
      prev_intr = intr;
    end
    bus.s_valid = 1'b0;
    total++;
    if ({nd, level, busy} !== {32'd5, 3'd0, 1'b0}) begin
      bad++; $display("FAIL b2b_done: got nd=%0d lvl=%0d busy=%b want 5 0 0", nd, level, busy);
    end
  endtask

  task automatic test_enable();
    en = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h66;
    step(1);
    bus.s_data  = 8'h77;
    step(1);
    bus.s_valid = 1'b0;
    step(4);
    total++;
    if ({intr, level, busy} !== {1'b0, 3'd2, 1'b0}) begin
      bad++; $display("FAIL en_low: got intr=%b lvl=%0d busy=%b want 0 2 0", intr, level, busy);
    end
    en = 1'b1;
    step(1);
    total++;
    if ({intr, in_port, busy} !== {1'b1, 8'h66, 1'b1}) begin
      bad++; $display("FAIL en_start: got intr=%b port=%h busy=%b want 1 66 1", intr, in_port, busy);
    end
    en = 1'b0;
    step(7);
    total++;
    if ({busy, level} !== {1'b0, 3'd1}) begin
      bad++; $display("FAIL en_complete: got busy=%b lvl=%0d want 0 1", busy, level);
    end
    for (int i = 0; i < 10; i++) begin
      step(1);
      total++;
      if ({intr, busy, in_port, level} !== {1'b0, 1'b0, 8'h66, 3'd1}) begin
        bad++; $display("FAIL en_nostart cyc%0d: got intr=%b busy=%b port=%h lvl=%0d want 0 0 66 1",
                        i, intr, busy, in_port, level);
      end
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h88;
    step(1);
    bus.s_data  = 8'h99;
    step(1);
    bus.s_valid = 1'b0;
    step(1);
    total++;
    if ({busy, intr, level, in_port} !== {1'b1, 1'b0, 3'd3, 8'h77}) begin
      bad++; $display("FAIL rstmid_hold: got busy=%b intr=%b lvl=%0d port=%h want 1 0 3 77",
                      busy, intr, level, in_port);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    total++;
    if ({intr, in_port, level, busy, bus.s_ready} !== {1'b0, 8'h00, 3'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL rstmid_after: got intr=%b port=%h lvl=%0d busy=%b rdy=%b want 0 00 0 0 1",
                      intr, in_port, level, busy, bus.s_ready);
    end
    for (int i = 0; i < 15; i++) begin
      step(1);
      total++;
      if ({intr, busy, level} !== {1'b0, 1'b0, 3'd0}) begin
        bad++; $display("FAIL rstmid_quiet cyc%0d: got intr=%b busy=%b lvl=%0d want 0 0 0",
                        i, intr, busy, level);
      end
    end
  endtask

  task automatic test_fast();
    logic [7:0] fq [3];
    logic       exp_intr;
    fq = '{8'hC1, 8'hC2, 8'hC3};
    bus_f.s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_f.s_data = fq[i];
      step(1);
    end
    bus_f.s_valid = 1'b0;
    total++;
    if ({level_f, intr_f} !== {3'd3, 1'b0}) begin
      bad++; $display("FAIL fast_queued: got lvl=%0d intr=%b want 3 0", level_f, intr_f);
    end
    en_f = 1'b1;
    for (int e = 3; e < 15; e++) begin
      step(1);
      exp_intr = (e <= 9) && (e % 3 == 0);
      total++;
      if (intr_f !== exp_intr) begin
        bad++; $display("FAIL fast_intr_e%0d: got %b want %b", e, intr_f, exp_intr);
      end
      if (exp_intr) begin
        total++;
        if (in_port_f !== fq[(e-3)/3]) begin
          bad++; $display("FAIL fast_port_e%0d: got %h want %h", e, in_port_f, fq[(e-3)/3]);
        end
      end
    end
    total++;
    if ({level_f, busy_f, in_port_f} !== {3'd0, 1'b0, 8'hC3}) begin
      bad++; $display("FAIL fast_done: got lvl=%0d busy=%b port=%h want 0 0 c3", level_f, busy_f, in_port_f);
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    en_f = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = 8'h00;
    bus_f.s_valid = 1'b0;
    bus_f.s_data = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    test_fast();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
